msrv32_store_buffer: RTL and testbench
======================================

// Module: msrv32_store_buffer
// PURPOSE
//  Parametrised posted-store buffer between the execute stage and the AHB data port.
//  Accepts one store per cycle: funct3 size, effective address and rs2 data.
//  Steers data and byte mask onto lanes and queues the write in a DEPTH-entry FIFO.
//  Issues writes in order under the ahb_ready_in handshake; flags misaligned stores.
// PARAMETERS
//  DATA_W  32  data bus width; 32 or 64 only. NB = DATA_W/8 byte lanes, OB = log2(NB).
//  ADDR_W  32  address width.
//  DEPTH   4   FIFO entries; power of two, >= 2. CW = log2(DEPTH)+1.
// PORTS
//  ms_riscv32_mp_clk_in         in   1       clock; all state on rising edge
//  ms_riscv32_mp_rst_in         in   1       synchronous reset, active-high
//  store_valid_in               in   1       store request this cycle
//  store_ready_out              out  1       buffer can accept; = (count != DEPTH)
//  funct3_in                    in   2       00 byte, 01 half, 10 word, 11 dword
//  iadder_in                    in   ADDR_W  effective byte address
//  rs2_in                       in   DATA_W  store data, right-aligned
//  ahb_ready_in                 in   1       slave accepts the presented write
//  ms_riscv32_mp_dmaddr_out     out  ADDR_W  head address, low OB bits forced 0
//  ms_riscv32_mp_dmdata_out     out  DATA_W  head data, lane-steered
//  ms_riscv32_mp_dmwr_mask_out  out  NB      head byte-enable mask
//  ms_riscv32_mp_dmwr_req_out   out  1       head valid; = (count != 0)
//  ahb_htrans_out               out  2       2'b10 (NONSEQ) when req, else 2'b00 (IDLE)
//  misaligned_out               out  1       1-cycle pulse: a store was rejected
//  count_out                    out  CW      current occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset: count=0, ptrs=0, misaligned_out=0, req=0, htrans=00.
//   Entry storage is not cleared; addr/data/mask outputs show head entry (don't-care when req=0).
//   Reset mid-operation discards every queued store, including one currently presented.
//  Size: bytes = 1<<funct3_in. funct3=11 with DATA_W=32 is illegal and is rejected as misaligned.
//  Alignment: legal iff iadder_in[log2(bytes)-1:0]==0; byte stores are always legal.
//  Push: store_valid_in & store_ready_out & legal. Entry written at wr_ptr.
//   off = iadder_in[OB-1:0]; data = (rs2_in masked to bytes) << (8*off).
//   mask = ((1<<bytes)-1) << off. Unused lanes carry 0 in data and 0 in mask.
//   addr = {iadder_in[ADDR_W-1:OB], OB'b0}.
//  Reject: store_valid_in & store_ready_out & !legal.
//   Nothing is enqueued; misaligned_out=1 in the following cycle only.
//   store_valid_in while ready=0: ignored, no pulse; the source must hold it.
//  Pop: dmwr_req_out & ahb_ready_in. Head retires and rd_ptr advances.
//   Outputs stay stable while req=1 & ahb_ready_in=0 (AHB hold rule).
//  Latency: store pushed in cycle N into an empty buffer gives req=1 with its data in cycle N+1.
//   Best-case throughput is one store per cycle.
//  Simultaneous push and pop: count unchanged and order preserved.
//   Legal when count<DEPTH; at count==DEPTH ready=0, so no push that cycle.
//   There is no combinational path from ahb_ready_in to store_ready_out.
//  Pointers wrap modulo DEPTH. count is never below 0 or above DEPTH.
// TESTING
//  T1 DATA_W=32: SB addr 0x1003, rs2 0xAABBCCDD -> next cycle dmaddr 0x1000, data 0xDD000000, mask 1000, htrans 10.
//  T2 DATA_W=32: SH 0x2002 data 0x1234 -> data 0x12340000, mask 1100.
//     Then SH 0x2001 -> misaligned_out pulses 1 cycle, count unchanged.
//  T3 Fill: ahb_ready_in=0, push 4 SW -> count 4, ready=0. 5th valid held ->
//     ready=1 the cycle after one pop, then accepted; FIFO order verified.
//  T4 DATA_W=64: SD 0x3000 -> mask 0xFF. SW 0x3004 -> mask 0xF0, data in [63:32].
//     With DATA_W=32, funct3=11 -> rejected.
//  T5 Steady push+pop with ahb_ready_in=1, 16 stores -> count stays 1, 16 writes in order, no gaps.
//  T6 Reset asserted with count=3 and req held by ready=0 -> next cycle req=0, count=0, htrans=00.

Source files
------------

// File: rtl/msrv32_store_buffer_if.sv
// ---------------------------------------------------------------------------
// msrv32_store_buffer_if
//
// Bundles the execute-side store request and the AHB-side write port of the
// posted-store buffer.
//
//   slave  modport : the store buffer's view (takes stores and AHB ready,
//                    drives the head write and status)
//   master modport : the environment's view (execute stage + AHB slave)
//
// Signals
//   store_valid_in              store request this cycle
//   store_ready_out             buffer can accept a store
//   funct3_in[1:0]              store size: 00 byte, 01 half, 10 word, 11 dword
//   iadder_in[ADDR_W]           effective byte address
//   rs2_in[DATA_W]              store data, right-aligned
//   ahb_ready_in                slave accepts the presented write
//   ms_riscv32_mp_dmaddr_out    head address, lane bits forced to 0
//   ms_riscv32_mp_dmdata_out    head data, lane-steered
//   ms_riscv32_mp_dmwr_mask_out head byte-enable mask
//   ms_riscv32_mp_dmwr_req_out  head entry valid
//   ahb_htrans_out[1:0]         NONSEQ while a write is presented, else IDLE
//   misaligned_out              one-cycle pulse: a store was rejected
//   count_out[CW]               current occupancy
// ---------------------------------------------------------------------------
interface msrv32_store_buffer_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
);
   localparam int NB = DATA_W / 8;
   localparam int CW = $clog2(DEPTH) + 1;

   logic              store_valid_in;
   logic              store_ready_out;
   logic [1:0]        funct3_in;
   logic [ADDR_W-1:0] iadder_in;
   logic [DATA_W-1:0] rs2_in;
   logic              ahb_ready_in;
   logic [ADDR_W-1:0] ms_riscv32_mp_dmaddr_out;
   logic [DATA_W-1:0] ms_riscv32_mp_dmdata_out;
   logic [NB-1:0]     ms_riscv32_mp_dmwr_mask_out;
   logic              ms_riscv32_mp_dmwr_req_out;
   logic [1:0]        ahb_htrans_out;
   logic              misaligned_out;
   logic [CW-1:0]     count_out;

   modport slave (
      input  store_valid_in,
      input  funct3_in,
      input  iadder_in,
      input  rs2_in,
      input  ahb_ready_in,
      output store_ready_out,
      output ms_riscv32_mp_dmaddr_out,
      output ms_riscv32_mp_dmdata_out,
      output ms_riscv32_mp_dmwr_mask_out,
      output ms_riscv32_mp_dmwr_req_out,
      output ahb_htrans_out,
      output misaligned_out,
      output count_out
   );

   modport master (
      output store_valid_in,
      output funct3_in,
      output iadder_in,
      output rs2_in,
      output ahb_ready_in,
      input  store_ready_out,
      input  ms_riscv32_mp_dmaddr_out,
      input  ms_riscv32_mp_dmdata_out,
      input  ms_riscv32_mp_dmwr_mask_out,
      input  ms_riscv32_mp_dmwr_req_out,
      input  ahb_htrans_out,
      input  misaligned_out,
      input  count_out
   );
endinterface

// File: rtl/msrv32_store_buffer.sv
// ---------------------------------------------------------------------------
// msrv32_store_buffer
//
// Posted-store buffer between the execute stage and the AHB data port.
// One store per cycle is accepted, its data and byte mask are steered onto
// the bus lanes, and the write is queued in a DEPTH-entry FIFO.  The head
// entry is presented on the AHB write port and retires when ahb_ready_in is
// high.  Misaligned stores (and dword stores on a 32-bit bus) are dropped and
// reported with a one-cycle misaligned_out pulse.
//
// Parameters
//   DATA_W  data bus width, 32 or 64
//   ADDR_W  address width (>= 3)
//   DEPTH   FIFO entries, power of two, >= 2
//
// Ports
//   ms_riscv32_mp_clk_in  clock, all state on the rising edge
//   ms_riscv32_mp_rst_in  synchronous active-high reset
//   sb_if                 store request / AHB write bundle (slave modport)
// ---------------------------------------------------------------------------
module msrv32_store_buffer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
) (
   input logic                  ms_riscv32_mp_clk_in,
   input logic                  ms_riscv32_mp_rst_in,
   msrv32_store_buffer_if.slave sb_if
);

   localparam int NB = DATA_W / 8;          // byte lanes
   localparam int OB = $clog2(NB);          // lane-offset bits
   localparam int PW = $clog2(DEPTH);       // pointer width
   localparam int CW = PW + 1;              // occupancy width, holds 0..DEPTH
   localparam logic DWORD_OK = (DATA_W == 64);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              misaligned_q, misaligned_d;

   // Entry storage is never reset; only the pointers/count define validity.
   logic [ADDR_W-1:0] addr_mem_q [DEPTH];
   logic [DATA_W-1:0] data_mem_q [DEPTH];
   logic [NB-1:0]     mask_mem_q [DEPTH];

   // ------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------
   logic              size_ok;
   logic              align_ok;
   logic              legal;
   logic              ready;
   logic              req;
   logic              accept;
   logic              push;
   logic              reject;
   logic              pop;
   logic [OB-1:0]     lane_off;
   logic [NB-1:0]     lane_en;
   logic [DATA_W-1:0] data_trim;
   logic [DATA_W-1:0] data_steer;
   logic [NB-1:0]     mask_steer;
   logic [ADDR_W-1:0] addr_line;

   // A dword store only exists when the bus is 64 bits wide.
   assign size_ok = (sb_if.funct3_in != 2'b11) || DWORD_OK;

   always_comb begin
      align_ok = 1'b1;
      case (sb_if.funct3_in)
         2'b00:   align_ok = 1'b1;
         2'b01:   align_ok = (sb_if.iadder_in[0] == 1'b0);
         2'b10:   align_ok = (sb_if.iadder_in[1:0] == 2'b00);
         default: align_ok = (sb_if.iadder_in[2:0] == 3'b000);
      endcase
   end

   assign legal    = size_ok & align_ok;
   assign lane_off = sb_if.iadder_in[OB-1:0];

   // Lane enables for the right-aligned operand: lanes below the store size.
   // Bytes of rs2 above the store size are zeroed before steering so unused
   // lanes always carry 0.
   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_lane
         assign lane_en[gi] = (32'(gi) < (32'd1 << sb_if.funct3_in));
         assign data_trim[8*gi +: 8] = lane_en[gi] ? sb_if.rs2_in[8*gi +: 8] : 8'h00;
      end
   endgenerate

   // Alignment guarantees the shifted operand never runs off the top lane.
   assign data_steer = data_trim << {lane_off, 3'b000};
   assign mask_steer = lane_en << lane_off;
   assign addr_line  = {sb_if.iadder_in[ADDR_W-1:OB], {OB{1'b0}}};

   // ------------------------------------------------------------------
   // Handshakes
   // ------------------------------------------------------------------
   // ready depends only on registered occupancy, so ahb_ready_in has no
   // combinational path to store_ready_out.
   assign ready  = (count_q != FULL_COUNT);
   assign req    = (count_q != '0);
   assign accept = sb_if.store_valid_in & ready;
   assign push   = accept & legal;
   assign reject = accept & ~legal;
   assign pop    = req & sb_if.ahb_ready_in;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q + CW'(push) - CW'(pop);
      misaligned_d = reject;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);   // power-of-two depth wraps naturally
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Control registers
   // ------------------------------------------------------------------
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (ms_riscv32_mp_rst_in) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         misaligned_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         misaligned_q <= misaligned_d;
      end
   end

   // ------------------------------------------------------------------
   // Entry storage: write at wr_ptr, head read at rd_ptr
   // ------------------------------------------------------------------
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (push && !ms_riscv32_mp_rst_in) begin
         addr_mem_q[wr_ptr_q] <= addr_line;
         data_mem_q[wr_ptr_q] <= data_steer;
         mask_mem_q[wr_ptr_q] <= mask_steer;
      end
   end

   // The head is read straight from storage so a store pushed into an empty
   // buffer is presented the very next cycle; the head only changes on a pop,
   // which keeps the outputs stable while the slave inserts wait states.
   assign sb_if.ms_riscv32_mp_dmaddr_out    = addr_mem_q[rd_ptr_q];
   assign sb_if.ms_riscv32_mp_dmdata_out    = data_mem_q[rd_ptr_q];
   assign sb_if.ms_riscv32_mp_dmwr_mask_out = mask_mem_q[rd_ptr_q];
   assign sb_if.ms_riscv32_mp_dmwr_req_out  = req;
   assign sb_if.ahb_htrans_out              = req ? 2'b10 : 2'b00;
   assign sb_if.store_ready_out             = ready;
   assign sb_if.misaligned_out              = misaligned_q;
   assign sb_if.count_out                   = count_q;

endmodule

// File: tb/tb_msrv32_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_msrv32_store_buffer
//
// Directed bench for the posted-store buffer.  A 32-bit and a 64-bit instance
// share clock and reset.  Every accepted store pushes its expected bus write
// into a per-instance queue; a negedge monitor pops and compares whenever a
// write retires (req & ahb_ready).  Inputs change 1 time unit after the
// rising edge and state outputs are checked there as well.
// ---------------------------------------------------------------------------
module tb_msrv32_store_buffer;

   typedef struct {
      logic [63:0] a;
      logic [63:0] d;
      logic [7:0]  m;
   } exp_t;

   logic clk;
   logic rst;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   int n_wr32  = 0;
   int n_wr64  = 0;

   exp_t q32[$];
   exp_t q64[$];

   msrv32_store_buffer_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) if32 ();
   msrv32_store_buffer_if #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) if64 ();

   msrv32_store_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) u_dut32 (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst),
      .sb_if                (if32.slave)
   );

   msrv32_store_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) u_dut64 (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst),
      .sb_if                (if64.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no completion, required $finish before 100000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv32(input logic v, input logic [1:0] f, input logic [31:0] a, input logic [31:0] d);
      if32.store_valid_in = v;
      if32.funct3_in      = f;
      if32.iadder_in      = a;
      if32.rs2_in         = d;
   endtask

   task automatic drv64(input logic v, input logic [1:0] f, input logic [31:0] a, input logic [63:0] d);
      if64.store_valid_in = v;
      if64.funct3_in      = f;
      if64.iadder_in      = a;
      if64.rs2_in         = d;
   endtask

   task automatic drain32();
      if32.ahb_ready_in = 1'b1;
      for (int k = 0; k < 32; k++) begin
         if (if32.count_out == 3'd0) break;
         tick();
      end
      check("drain32_count", 64'(if32.count_out), 64'd0);
      check("drain32_sb_empty", 64'(q32.size()), 64'd0);
      if32.ahb_ready_in = 1'b0;
   endtask

   task automatic drain64();
      if64.ahb_ready_in = 1'b1;
      for (int k = 0; k < 32; k++) begin
         if (if64.count_out == 3'd0) break;
         tick();
      end
      check("drain64_count", 64'(if64.count_out), 64'd0);
      check("drain64_sb_empty", 64'(q64.size()), 64'd0);
      if64.ahb_ready_in = 1'b0;
   endtask

   // Scoreboard monitors: one line per retired write.
   always @(negedge clk) begin
      if (!rst && if32.ms_riscv32_mp_dmwr_req_out && if32.ahb_ready_in) begin
         exp_t e;
         n_wr32++;
         n_total++;
         assert (q32.size() != 0) n_pass++;
         else begin
            n_fail++;
            $error("FAIL wr32_unexpected: observed write addr 0x%0h, required no write",
                   if32.ms_riscv32_mp_dmaddr_out);
         end
         if (q32.size() != 0) begin
            e = q32.pop_front();
            $display("wr32 addr=0x%08h data=0x%08h mask=0x%h", if32.ms_riscv32_mp_dmaddr_out,
                     if32.ms_riscv32_mp_dmdata_out, if32.ms_riscv32_mp_dmwr_mask_out);
            check("wr32_addr", 64'(if32.ms_riscv32_mp_dmaddr_out), e.a);
            check("wr32_data", 64'(if32.ms_riscv32_mp_dmdata_out), e.d);
            check("wr32_mask", 64'(if32.ms_riscv32_mp_dmwr_mask_out), 64'(e.m));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && if64.ms_riscv32_mp_dmwr_req_out && if64.ahb_ready_in) begin
         exp_t e;
         n_wr64++;
         n_total++;
         assert (q64.size() != 0) n_pass++;
         else begin
            n_fail++;
            $error("FAIL wr64_unexpected: observed write addr 0x%0h, required no write",
                   if64.ms_riscv32_mp_dmaddr_out);
         end
         if (q64.size() != 0) begin
            e = q64.pop_front();
            $display("wr64 addr=0x%08h data=0x%016h mask=0x%h", if64.ms_riscv32_mp_dmaddr_out,
                     if64.ms_riscv32_mp_dmdata_out, if64.ms_riscv32_mp_dmwr_mask_out);
            check("wr64_addr", 64'(if64.ms_riscv32_mp_dmaddr_out), e.a);
            check("wr64_data", if64.ms_riscv32_mp_dmdata_out, e.d);
            check("wr64_mask", 64'(if64.ms_riscv32_mp_dmwr_mask_out), 64'(e.m));
         end
      end
   end

   initial begin
      int wr_before;
      logic [31:0] rnd;

      rst = 1'b1;
      drv32(1'b0, 2'b00, 32'h0, 32'h0);
      drv64(1'b0, 2'b00, 32'h0, 64'h0);
      if32.ahb_ready_in = 1'b0;
      if64.ahb_ready_in = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_count32", 64'(if32.count_out), 64'd0);
      check("rst_req32", 64'(if32.ms_riscv32_mp_dmwr_req_out), 64'd0);
      check("rst_htrans32", 64'(if32.ahb_htrans_out), 64'd0);
      check("rst_mis32", 64'(if32.misaligned_out), 64'd0);
      check("rst_ready32", 64'(if32.store_ready_out), 64'd1);
      check("rst_count64", 64'(if64.count_out), 64'd0);
      check("rst_req64", 64'(if64.ms_riscv32_mp_dmwr_req_out), 64'd0);

      // T1: byte store on the top lane, upper rs2 bytes must be discarded
      drv32(1'b1, 2'b00, 32'h0000_1003, 32'hAABB_CCDD);
      q32.push_back('{a: 64'h1000, d: 64'hDD00_0000, m: 8'h08});
      tick();
      drv32(1'b0, 2'b00, 32'h0, 32'h0);
      check("t1_req", 64'(if32.ms_riscv32_mp_dmwr_req_out), 64'd1);
      check("t1_htrans", 64'(if32.ahb_htrans_out), 64'h2);
      check("t1_addr", 64'(if32.ms_riscv32_mp_dmaddr_out), 64'h1000);
      check("t1_data", 64'(if32.ms_riscv32_mp_dmdata_out), 64'hDD00_0000);
      check("t1_mask", 64'(if32.ms_riscv32_mp_dmwr_mask_out), 64'h8);
      check("t1_count", 64'(if32.count_out), 64'd1);

      // T2: half store on lanes 2-3, then a misaligned half store
      drv32(1'b1, 2'b01, 32'h0000_2002, 32'hFFFF_1234);
      q32.push_back('{a: 64'h2000, d: 64'h1234_0000, m: 8'h0C});
      tick();
      check("t2_count", 64'(if32.count_out), 64'd2);
      check("t2_hold_addr", 64'(if32.ms_riscv32_mp_dmaddr_out), 64'h1000);
      drv32(1'b1, 2'b01, 32'h0000_2001, 32'h0000_5678);
      tick();
      drv32(1'b0, 2'b00, 32'h0, 32'h0);
      check("t2_mis_pulse", 64'(if32.misaligned_out), 64'd1);
      check("t2_mis_count", 64'(if32.count_out), 64'd2);
      tick();
      check("t2_mis_clear", 64'(if32.misaligned_out), 64'd0);
      check("t2_count_after", 64'(if32.count_out), 64'd2);
      drain32();

      // T3: fill with the slave stalled, hold a fifth store until space frees
      for (int i = 0; i < 4; i++) begin
         drv32(1'b1, 2'b10, 32'h4000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
         q32.push_back('{a: 64'h4000 + 64'(4 * i), d: 64'(32'h1111_1111 * 32'(i + 1)), m: 8'h0F});
         tick();
      end
      drv32(1'b1, 2'b10, 32'h0000_4010, 32'h5555_5555);
      q32.push_back('{a: 64'h4010, d: 64'h5555_5555, m: 8'h0F});
      check("t3_full_count", 64'(if32.count_out), 64'd4);
      check("t3_full_ready", 64'(if32.store_ready_out), 64'd0);
      tick();
      check("t3_held_count", 64'(if32.count_out), 64'd4);
      check("t3_held_mis", 64'(if32.misaligned_out), 64'd0);
      if32.ahb_ready_in = 1'b1;
      #1;
      check("t3_no_comb_ready", 64'(if32.store_ready_out), 64'd0);
      tick();
      if32.ahb_ready_in = 1'b0;
      check("t3_pop_count", 64'(if32.count_out), 64'd3);
      check("t3_pop_ready", 64'(if32.store_ready_out), 64'd1);
      tick();
      drv32(1'b0, 2'b00, 32'h0, 32'h0);
      check("t3_accept_count", 64'(if32.count_out), 64'd4);
      drain32();

      // T4: 64-bit lanes, and dword rejected on the 32-bit bus
      drv64(1'b1, 2'b11, 32'h0000_3000, 64'h0123_4567_89AB_CDEF);
      q64.push_back('{a: 64'h3000, d: 64'h0123_4567_89AB_CDEF, m: 8'hFF});
      tick();
      drv64(1'b1, 2'b10, 32'h0000_3004, 64'hFFFF_FFFF_DEAD_BEEF);
      q64.push_back('{a: 64'h3000, d: 64'hDEAD_BEEF_0000_0000, m: 8'hF0});
      check("t4_sd_mask", 64'(if64.ms_riscv32_mp_dmwr_mask_out), 64'hFF);
      tick();
      drv64(1'b0, 2'b00, 32'h0, 64'h0);
      check("t4_count64", 64'(if64.count_out), 64'd2);
      drain64();
      drv32(1'b1, 2'b11, 32'h0000_5000, 32'h1234_5678);
      tick();
      drv32(1'b0, 2'b00, 32'h0, 32'h0);
      check("t4_dw32_mis", 64'(if32.misaligned_out), 64'd1);
      check("t4_dw32_count", 64'(if32.count_out), 64'd0);
      check("t4_dw32_req", 64'(if32.ms_riscv32_mp_dmwr_req_out), 64'd0);

      // T5: back-to-back push + pop
      wr_before = n_wr32;
      if32.ahb_ready_in = 1'b1;
      for (int i = 0; i < 16; i++) begin
         rnd = $urandom();
         drv32(1'b1, 2'b10, 32'h6000 + 32'(4 * i), rnd);
         q32.push_back('{a: 64'h6000 + 64'(4 * i), d: 64'(rnd), m: 8'h0F});
         tick();
         check("t5_count", 64'(if32.count_out), 64'd1);
      end
      drv32(1'b0, 2'b00, 32'h0, 32'h0);
      tick();
      check("t5_count_end", 64'(if32.count_out), 64'd0);
      check("t5_writes", 64'(n_wr32 - wr_before), 64'd16);
      if32.ahb_ready_in = 1'b0;

      // T6: reset with three stalled stores
      for (int i = 0; i < 3; i++) begin
         drv32(1'b1, 2'b10, 32'h7100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
         tick();
      end
      drv32(1'b0, 2'b00, 32'h0, 32'h0);
      check("t6_pre_count", 64'(if32.count_out), 64'd3);
      check("t6_pre_req", 64'(if32.ms_riscv32_mp_dmwr_req_out), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_req", 64'(if32.ms_riscv32_mp_dmwr_req_out), 64'd0);
      check("t6_count", 64'(if32.count_out), 64'd0);
      check("t6_htrans", 64'(if32.ahb_htrans_out), 64'd0);
      drv32(1'b1, 2'b10, 32'h0000_7000, 32'hFACE_B00C);
      q32.push_back('{a: 64'h7000, d: 64'hFACE_B00C, m: 8'h0F});
      tick();
      drv32(1'b0, 2'b00, 32'h0, 32'h0);
      check("t6_post_addr", 64'(if32.ms_riscv32_mp_dmaddr_out), 64'h7000);
      drain32();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
